// File: rtl/pipe_ctrl_pkg.sv
// Shared constants for the pipeline hazard controller:
// PC-source codes, branch condition codes and FSM state encoding.
package pipe_ctrl_pkg;

    localparam logic [1:0] PC_SEL_PC4  = 2'd0;
    localparam logic [1:0] PC_SEL_BR   = 2'd1;
    localparam logic [1:0] PC_SEL_EXC  = 2'd2;
    localparam logic [1:0] PC_SEL_EPC  = 2'd3;

    localparam logic [2:0] COND_EQ     = 3'd0;
    localparam logic [2:0] COND_NE     = 3'd1;
    localparam logic [2:0] COND_LT     = 3'd2;
    localparam logic [2:0] COND_GE     = 3'd3;
    localparam logic [2:0] COND_LE     = 3'd4;
    localparam logic [2:0] COND_GT     = 3'd5;
    localparam logic [2:0] COND_ALWAYS = 3'd6;
    localparam logic [2:0] COND_NEVER  = 3'd7;

    localparam int         STATE_W     = 1;
    localparam logic [0:0] ST_RUN      = 1'b0;
    localparam logic [0:0] ST_MEM_WAIT = 1'b1;

endpackage

// File: rtl/pipe_hazard_ctrl_branch_cond_eval.sv
// Branch condition evaluator: maps a condition code and the
// latched ALU flags to a taken decision. Unknown codes never take.
module branch_cond_eval
    import pipe_ctrl_pkg::*;
(
    input  logic [2:0] condition,
    input  logic       lf,
    input  logic       zf,
    output logic       taken
);

    // Decode the condition code against the less-than/zero flags
    always_comb begin
        taken = 1'b0;
        case (condition)
            COND_EQ:     taken = zf;
            COND_NE:     taken = ~zf;
            COND_LT:     taken = lf;
            COND_GE:     taken = ~lf;
            COND_LE:     taken = lf | zf;
            COND_GT:     taken = ~lf & ~zf;
            COND_ALWAYS: taken = 1'b1;
            default:     taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush scheduler for the 5-stage pipeline.
// Priority: exception > taken branch > memory wait > load-use.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       idex_mem_r,
    input  logic [4:0] idex_rd_addr,
    input  logic [4:0] ifid_rs_addr,
    input  logic [4:0] ifid_rt_addr,
    input  logic       exmem_branch,
    input  logic [2:0] exmem_condition,
    input  logic       exmem_lf,
    input  logic       exmem_zf,
    input  logic       exmem_mem_r,
    input  logic       exmem_mem_w,
    input  logic       mem_ready,
    input  logic       exmem_syscall,
    input  logic       exmem_eret,
    output logic       pc_stall,
    output logic       ifid_stall,
    output logic       idex_stall,
    output logic       exmem_stall,
    output logic       ifid_flush,
    output logic       idex_flush,
    output logic       exmem_flush,
    output logic       memwb_flush,
    output logic [1:0] pc_sel,
    output logic       mem_req,
    output logic       epc_w_en,
    output logic       bus_err
);

    logic [STATE_W-1:0] state_q, state_d;
    logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic               cond_true;
    logic               taken;
    logic               mem_access;
    logic               mem_wait;
    logic               timeout;
    logic               exc;
    logic               load_use;

    branch_cond_eval u_cond (
        .condition (exmem_condition),
        .lf        (exmem_lf),
        .zf        (exmem_zf),
        .taken     (cond_true)
    );

    // Hazard detection terms shared by outputs and next-state logic
    always_comb begin
        taken      = exmem_branch & cond_true;
        mem_access = exmem_mem_r | exmem_mem_w;
        mem_wait   = mem_access & ~mem_ready;
        timeout    = (state_q == ST_MEM_WAIT) & mem_wait &
                     (wait_cnt_q == CNT_W'(MEM_TIMEOUT - 1));
        exc        = exmem_syscall | exmem_eret | timeout;
        load_use   = idex_mem_r & (idex_rd_addr != 5'd0) &
                     ((idex_rd_addr == ifid_rs_addr) |
                      (idex_rd_addr == ifid_rt_addr));
    end

    // Prioritised stall/flush/PC-select generation
    always_comb begin
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        idex_stall  = 1'b0;
        exmem_stall = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        pc_sel      = PC_SEL_PC4;
        mem_req     = 1'b0;
        epc_w_en    = 1'b0;
        bus_err     = 1'b0;
        if (reset) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            memwb_flush = 1'b1;
        end else if (exc) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            bus_err     = timeout;
            if (exmem_syscall | timeout) begin
                pc_sel   = PC_SEL_EXC;
                epc_w_en = 1'b1;
            end else begin
                pc_sel   = PC_SEL_EPC;
            end
        end else if (taken) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            pc_sel      = PC_SEL_BR;
            mem_req     = mem_access;
        end else if (mem_wait) begin
            // whole front end held; load-use is implicitly covered
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_stall  = 1'b1;
            exmem_stall = 1'b1;
            memwb_flush = 1'b1;
            mem_req     = 1'b1;
        end else begin
            mem_req     = mem_access;
            if (load_use) begin
                pc_stall   = 1'b1;
                ifid_stall = 1'b1;
                idex_flush = 1'b1;
            end
        end
        // a bubble overrides a hold on the same stage
        ifid_stall  = ifid_stall & ~ifid_flush;
        idex_stall  = idex_stall & ~idex_flush;
        exmem_stall = exmem_stall & ~exmem_flush;
    end

    // Memory-wait FSM and consecutive wait-cycle counter
    always_comb begin
        state_d    = ST_RUN;
        wait_cnt_d = '0;
        if (!exc && !taken && mem_wait) begin
            state_d    = ST_MEM_WAIT;
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
    end

    // State registers, synchronous active-high reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: vector table plus
// hand-written multi-cycle sequences, checked via an expect queue.
module tb_pipe_hazard_ctrl;

    typedef struct packed {
        logic       rst;
        logic       ld;
        logic [4:0] rd;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       br;
        logic [2:0] cond;
        logic       lf;
        logic       zf;
        logic       mr;
        logic       mw;
        logic       rdy;
        logic       sc;
        logic       er;
    } in_t;

    // stall = {pc,ifid,idex,exmem}, flush = {ifid,idex,exmem,memwb}
    typedef struct packed {
        logic [3:0] stall;
        logic [3:0] flush;
        logic [1:0] sel;
        logic       req;
        logic       epc;
        logic       berr;
    } out_t;

    typedef struct packed {
        in_t  i;
        out_t o;
    } vec_t;

    localparam int NV = 26;

    logic       clk = 1'b0;
    logic       reset;
    logic       idex_mem_r;
    logic [4:0] idex_rd_addr;
    logic [4:0] ifid_rs_addr;
    logic [4:0] ifid_rt_addr;
    logic       exmem_branch;
    logic [2:0] exmem_condition;
    logic       exmem_lf;
    logic       exmem_zf;
    logic       exmem_mem_r;
    logic       exmem_mem_w;
    logic       mem_ready;
    logic       exmem_syscall;
    logic       exmem_eret;
    logic       pc_stall;
    logic       ifid_stall;
    logic       idex_stall;
    logic       exmem_stall;
    logic       ifid_flush;
    logic       idex_flush;
    logic       exmem_flush;
    logic       memwb_flush;
    logic [1:0] pc_sel;
    logic       mem_req;
    logic       epc_w_en;
    logic       bus_err;

    int   n_checks = 0;
    int   n_fails  = 0;
    out_t exp_q[$];
    string name_q[$];
    vec_t vecs[NV];

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .MEM_TIMEOUT (4),
        .CNT_W       (8)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .idex_mem_r      (idex_mem_r),
        .idex_rd_addr    (idex_rd_addr),
        .ifid_rs_addr    (ifid_rs_addr),
        .ifid_rt_addr    (ifid_rt_addr),
        .exmem_branch    (exmem_branch),
        .exmem_condition (exmem_condition),
        .exmem_lf        (exmem_lf),
        .exmem_zf        (exmem_zf),
        .exmem_mem_r     (exmem_mem_r),
        .exmem_mem_w     (exmem_mem_w),
        .mem_ready       (mem_ready),
        .exmem_syscall   (exmem_syscall),
        .exmem_eret      (exmem_eret),
        .pc_stall        (pc_stall),
        .ifid_stall      (ifid_stall),
        .idex_stall      (idex_stall),
        .exmem_stall     (exmem_stall),
        .ifid_flush      (ifid_flush),
        .idex_flush      (idex_flush),
        .exmem_flush     (exmem_flush),
        .memwb_flush     (memwb_flush),
        .pc_sel          (pc_sel),
        .mem_req         (mem_req),
        .epc_w_en        (epc_w_en),
        .bus_err         (bus_err)
    );

    function automatic in_t mk_in(
        logic rst, logic ld, logic [4:0] rd, logic [4:0] rs,
        logic [4:0] rt, logic br, logic [2:0] cond, logic lf,
        logic zf, logic mr, logic mw, logic rdy, logic sc,
        logic er);
        in_t v;
        v = '{rst, ld, rd, rs, rt, br, cond, lf, zf, mr, mw,
              rdy, sc, er};
        return v;
    endfunction

    function automatic out_t mk_out(
        logic [3:0] stall, logic [3:0] flush, logic [1:0] sel,
        logic req, logic epc, logic berr);
        out_t v;
        v = '{stall, flush, sel, req, epc, berr};
        return v;
    endfunction

    function automatic out_t dut_out();
        out_t v;
        v = '{{pc_stall, ifid_stall, idex_stall, exmem_stall},
              {ifid_flush, idex_flush, exmem_flush, memwb_flush},
              pc_sel, mem_req, epc_w_en, bus_err};
        return v;
    endfunction

    task automatic drive(input in_t v);
        reset           = v.rst;
        idex_mem_r      = v.ld;
        idex_rd_addr    = v.rd;
        ifid_rs_addr    = v.rs;
        ifid_rt_addr    = v.rt;
        exmem_branch    = v.br;
        exmem_condition = v.cond;
        exmem_lf        = v.lf;
        exmem_zf        = v.zf;
        exmem_mem_r     = v.mr;
        exmem_mem_w     = v.mw;
        mem_ready       = v.rdy;
        exmem_syscall   = v.sc;
        exmem_eret      = v.er;
    endtask

    task automatic check_one();
        out_t  e;
        out_t  a;
        string nm;
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        a  = dut_out();
        n_checks++;
        if (a !== e) begin
            n_fails++;
            $display("FAIL %s: got stall=%b flush=%b sel=%0d req=%b epc=%b berr=%b, need stall=%b flush=%b sel=%0d req=%b epc=%b berr=%b",
                     nm, a.stall, a.flush, a.sel, a.req, a.epc,
                     a.berr, e.stall, e.flush, e.sel, e.req,
                     e.epc, e.berr);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, check mid-cycle
    task automatic step(input in_t v, input out_t e, input string nm);
        drive(v);
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(negedge clk);
        check_one();
        @(posedge clk);
        #1;
    endtask

    in_t  i_idle;
    in_t  i_ldw;
    in_t  i_ldw_lu;
    in_t  i_ldok;
    in_t  i_rst_ldw;
    out_t o_none;
    out_t o_wait;
    out_t o_req;
    out_t o_tmo;
    out_t o_rst;

    initial begin
        i_idle    = mk_in(0,0,0,0,0,0,0,0,0,0,0,0,0,0);
        i_ldw     = mk_in(0,0,0,0,0,0,0,0,0,1,0,0,0,0);
        i_ldw_lu  = mk_in(0,1,5,5,0,0,0,0,0,1,0,0,0,0);
        i_ldok    = mk_in(0,0,0,0,0,0,0,0,0,1,0,1,0,0);
        i_rst_ldw = mk_in(1,0,0,0,0,0,0,0,0,1,0,0,0,0);
        o_none    = mk_out(4'b0000, 4'b0000, 2'd0, 0, 0, 0);
        o_wait    = mk_out(4'b1111, 4'b0001, 2'd0, 1, 0, 0);
        o_req     = mk_out(4'b0000, 4'b0000, 2'd0, 1, 0, 0);
        o_tmo     = mk_out(4'b0000, 4'b1110, 2'd2, 0, 1, 1);
        o_rst     = mk_out(4'b0000, 4'b1111, 2'd0, 0, 0, 0);

        // rst ld rd rs rt br cond lf zf mr mw rdy sc er
        vecs[0]  = '{mk_in(1,0,0,0,0,0,0,0,0,0,0,0,0,0), o_rst};
        vecs[1]  = '{i_idle, o_none};
        vecs[2]  = '{mk_in(0,1,5,5,0,0,0,0,0,0,0,0,0,0),
                     mk_out(4'b1100, 4'b0100, 2'd0, 0, 0, 0)};
        vecs[3]  = '{mk_in(0,1,7,3,7,0,0,0,0,0,0,0,0,0),
                     mk_out(4'b1100, 4'b0100, 2'd0, 0, 0, 0)};
        vecs[4]  = '{mk_in(0,1,0,0,0,0,0,0,0,0,0,0,0,0), o_none};
        vecs[5]  = '{mk_in(0,0,5,5,5,0,0,0,0,0,0,0,0,0), o_none};
        vecs[6]  = '{mk_in(0,0,0,0,0,1,0,0,1,0,0,0,0,0),
                     mk_out(4'b0000, 4'b1110, 2'd1, 0, 0, 0)};
        vecs[7]  = '{mk_in(0,0,0,0,0,1,0,0,0,0,0,0,0,0), o_none};
        vecs[8]  = '{mk_in(0,0,0,0,0,1,1,0,0,0,0,0,0,0),
                     mk_out(4'b0000, 4'b1110, 2'd1, 0, 0, 0)};
        vecs[9]  = '{mk_in(0,0,0,0,0,1,2,1,0,0,0,0,0,0),
                     mk_out(4'b0000, 4'b1110, 2'd1, 0, 0, 0)};
        vecs[10] = '{mk_in(0,0,0,0,0,1,3,1,0,0,0,0,0,0), o_none};
        vecs[11] = '{mk_in(0,0,0,0,0,1,4,0,1,0,0,0,0,0),
                     mk_out(4'b0000, 4'b1110, 2'd1, 0, 0, 0)};
        vecs[12] = '{mk_in(0,0,0,0,0,1,5,0,0,0,0,0,0,0),
                     mk_out(4'b0000, 4'b1110, 2'd1, 0, 0, 0)};
        vecs[13] = '{mk_in(0,0,0,0,0,1,5,0,1,0,0,0,0,0), o_none};
        vecs[14] = '{mk_in(0,0,0,0,0,1,6,0,0,0,0,0,0,0),
                     mk_out(4'b0000, 4'b1110, 2'd1, 0, 0, 0)};
        vecs[15] = '{mk_in(0,0,0,0,0,1,7,1,1,0,0,0,0,0), o_none};
        vecs[16] = '{mk_in(0,0,0,0,0,0,6,1,1,0,0,0,0,0), o_none};
        vecs[17] = '{mk_in(0,1,5,5,0,1,0,0,1,0,0,0,0,0),
                     mk_out(4'b0000, 4'b1110, 2'd1, 0, 0, 0)};
        vecs[18] = '{i_ldok, o_req};
        vecs[19] = '{mk_in(0,0,0,0,0,0,0,0,0,0,1,1,0,0), o_req};
        vecs[20] = '{mk_in(0,1,5,5,0,0,0,0,0,0,0,0,1,0),
                     mk_out(4'b0000, 4'b1110, 2'd2, 0, 1, 0)};
        vecs[21] = '{mk_in(0,0,0,0,0,0,0,0,0,0,0,0,0,1),
                     mk_out(4'b0000, 4'b1110, 2'd3, 0, 0, 0)};
        vecs[22] = '{mk_in(0,0,0,0,0,0,0,0,0,1,0,0,1,0),
                     mk_out(4'b0000, 4'b1110, 2'd2, 0, 1, 0)};
        vecs[23] = '{mk_in(0,0,0,0,0,1,6,0,0,0,0,0,1,0),
                     mk_out(4'b0000, 4'b1110, 2'd2, 0, 1, 0)};
        vecs[24] = '{mk_in(1,1,5,5,0,1,6,0,0,1,0,0,1,0), o_rst};
        vecs[25] = '{i_idle, o_none};

        drive(mk_in(1,0,0,0,0,0,0,0,0,0,0,0,0,0));
        repeat (2) @(posedge clk);
        #1;

        for (int k = 0; k < NV; k++)
            step(vecs[k].i, vecs[k].o, $sformatf("vec%0d", k));

        // load waits three cycles, load-use hidden, ready on 4th
        step(i_ldw,    o_wait, "ldwait_c1");
        step(i_ldw_lu, o_wait, "ldwait_c2_lu");
        step(i_ldw,    o_wait, "ldwait_c3");
        step(i_ldok,   o_req,  "ldwait_ready");
        step(i_idle,   o_none, "ldwait_back_run");

        // never ready: bus error on the 4th wait cycle, one pulse
        step(i_ldw,  o_wait, "tmo_c1");
        step(i_ldw,  o_wait, "tmo_c2");
        step(i_ldw,  o_wait, "tmo_c3");
        step(i_ldw,  o_tmo,  "tmo_c4_buserr");
        step(i_ldok, o_req,  "tmo_after");

        // reset during a wait restarts the counter from zero
        step(i_ldw,     o_wait, "rstw_c1");
        step(i_ldw,     o_wait, "rstw_c2");
        step(i_rst_ldw, o_rst,  "rstw_reset");
        step(i_ldw,     o_wait, "rstw_r1");
        step(i_ldw,     o_wait, "rstw_r2");
        step(i_ldw,     o_wait, "rstw_r3");
        step(i_ldw,     o_tmo,  "rstw_r4_buserr");
        step(i_idle,    o_none, "rstw_idle");

        if (exp_q.size() != 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL scoreboard_drain: got %0d left, need 0",
                     exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule
